// File: rtl/sipo_deserializer_if.sv
// Handshake/data bundle for sipo_deserializer: serial input side plus held-word output side.
interface sipo_deserializer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             serial_in;
  logic             bit_en;
  logic             frame_sync;
  logic             out_ready;
  logic [WIDTH-1:0] parallel_out;
  logic             out_valid;
  logic             overrun;
  logic [CNT_W-1:0] bit_count;
  logic             parity_err;

  modport master (
    output serial_in, bit_en, frame_sync, out_ready,
    input  parallel_out, out_valid, overrun, bit_count, parity_err
  );

  modport slave (
    input  serial_in, bit_en, frame_sync, out_ready,
    output parallel_out, out_valid, overrun, bit_count, parity_err
  );
endinterface

// File: rtl/sipo_deserializer.sv
// MSB-first serial-to-parallel receiver with valid/ready held word and sticky overrun.
// Optional even-parity bit after each word when PISO_RX_PARITY_EN is defined.
module sipo_deserializer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic                clk,
  input logic                rst,
  sipo_deserializer_if.slave bus
);

  typedef enum logic {COLLECT = 1'b0, PARITY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] hold_reg;
  logic [CNT_W-1:0] count;
  logic             valid;
  logic             ovr;
  logic             perr;

  logic [WIDTH-1:0] shifted;
  logic             word_done;
  logic [WIDTH-1:0] word_data;
  logic             word_perr;

  always_comb begin
    shifted = {shift_reg[WIDTH-2:0], bus.serial_in};
`ifdef PISO_RX_PARITY_EN
    // Data bits already sit in shift_reg; this edge carries the parity bit.
    word_done = bus.bit_en && !bus.frame_sync && (state == PARITY);
    word_data = shift_reg;
    word_perr = ^{shift_reg, bus.serial_in};
`else
    word_done = bus.bit_en && !bus.frame_sync && (state == COLLECT) && (count == LAST);
    word_data = shifted;
    word_perr = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      shift_reg <= '0;
      count     <= '0;
      hold_reg  <= '0;
      valid     <= 1'b0;
      ovr       <= 1'b0;
      perr      <= 1'b0;
    end else begin
      if (bus.frame_sync) begin
        state <= COLLECT;
        if (bus.bit_en) begin
          shift_reg <= {{(WIDTH-1){1'b0}}, bus.serial_in};
          count     <= CNT_W'(1);
        end else begin
          shift_reg <= '0;
          count     <= '0;
        end
      end else if (bus.bit_en) begin
        if (state == COLLECT) begin
          shift_reg <= shifted;
          if (count == LAST) begin
            count <= '0;
`ifdef PISO_RX_PARITY_EN
            state <= PARITY;
`endif
          end else begin
            count <= count + 1'b1;
          end
        end else begin
          state <= COLLECT;
        end
      end

      // A simultaneous transfer frees the holding register for the new word.
      if (word_done) begin
        if (!valid || bus.out_ready) begin
          hold_reg <= word_data;
          perr     <= word_perr;
          valid    <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end else if (valid && bus.out_ready) begin
        valid <= 1'b0;
      end
    end
  end

  assign bus.parallel_out = hold_reg;
  assign bus.out_valid    = valid;
  assign bus.overrun      = ovr;
  assign bus.bit_count    = count;
  assign bus.parity_err   = perr;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Randomized and directed bench for sipo_deserializer against a bit-queue reference model.
module tb_sipo_deserializer;
  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef PISO_RX_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int VW = WIDTH + CNT_W + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sipo_deserializer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  sipo_deserializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Reference model: received bits of the current frame, plus the held word.
  bit               q[$];
  logic [WIDTH-1:0] m_out;
  logic             m_valid, m_ovr, m_perr;

  function automatic logic [CNT_W-1:0] m_count();
    return CNT_W'((q.size() >= WIDTH) ? 0 : q.size());
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.parallel_out, bus.out_valid, bus.overrun, bus.bit_count, bus.parity_err};
  endfunction

  function automatic logic [VW-1:0] mdl_vec();
    return {m_out, m_valid, m_ovr, m_count(), m_perr};
  endfunction

  task automatic tick(input bit s, input bit en, input bit fs, input bit rdy);
    bit   done;
    int   w, ones;
    rst = 1'b0;
    bus.serial_in = s; bus.bit_en = en; bus.frame_sync = fs; bus.out_ready = rdy;
    @(posedge clk);
    done = 1'b0; w = 0; ones = 0;
    if (fs) begin
      q.delete();
      if (en) q.push_back(s);
    end else if (en) begin
      q.push_back(s);
      if (q.size() == NBITS) begin
        done = 1'b1;
        for (int i = 0; i < WIDTH; i++) w = w * 2 + int'(q[i]);
        foreach (q[i]) ones += int'(q[i]);
        q.delete();
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_out   = WIDTH'(w);
`ifdef PISO_RX_PARITY_EN
        m_perr  = (ones % 2) != 0;
`else
        m_perr  = 1'b0;
`endif
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.serial_in = 1'($urandom); bus.bit_en = 1'($urandom);
      bus.frame_sync = 1'($urandom); bus.out_ready = 1'($urandom);
      @(posedge clk);
    end
    q.delete(); m_out = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    #1;
  endtask

  function automatic bit frame_bit(input logic [WIDTH-1:0] d, input int i);
    return (i < WIDTH) ? d[WIDTH-1-i] : ^d;
  endfunction

  task automatic test_reset();
    do_reset(2);
    total++;
    if (dut_vec() !== '0) begin
      bad++; $display("FAIL reset_state: got %h want %h", dut_vec(), {VW{1'b0}});
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] d = 4'b1011;
    logic [CNT_W-1:0] cnt_exp[4] = '{1, 2, 3, 0};
    do_reset(1);
    for (int i = 0; i < NBITS; i++) begin
      tick(frame_bit(d, i), 1'b1, 1'b0, 1'b1);
      total++;
      if (dut_vec() !== mdl_vec()) begin
        bad++; $display("FAIL b2b_step%0d: got %h want %h", i, dut_vec(), mdl_vec());
      end
      if (i < 4) begin
        total++;
        if (bus.bit_count !== cnt_exp[i]) begin
          bad++; $display("FAIL b2b_count%0d: got %0d want %0d", i, bus.bit_count, cnt_exp[i]);
        end
      end
    end
    total++;
    if (bus.parallel_out !== 4'b1011 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_word: got %b/%b want 1011/1", bus.parallel_out, bus.out_valid);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (bus.out_valid !== 1'b0 || bus.parallel_out !== 4'b1011) begin
      bad++; $display("FAIL b2b_pulse: got %b/%b want 1011/0", bus.parallel_out, bus.out_valid);
    end
  endtask

  task automatic test_gapped();
    logic [WIDTH-1:0] d = 4'b0110;
    do_reset(1);
    for (int i = 0; i < NBITS; i++) begin
      for (int g = 0; g < 3; g++) begin
        tick(g == 2 ? frame_bit(d, i) : 1'($urandom), g == 2, 1'b0, 1'b1);
        total++;
        if (dut_vec() !== mdl_vec()) begin
          bad++; $display("FAIL gap_b%0d_g%0d: got %h want %h", i, g, dut_vec(), mdl_vec());
        end
      end
    end
    total++;
    if (bus.parallel_out !== 4'b0110 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL gap_word: got %b/%b want 0110/1", bus.parallel_out, bus.out_valid);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL gap_pulse: got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] words[2] = '{4'b1001, 4'b0110};
    do_reset(1);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NBITS; i++) begin
        tick(frame_bit(words[k], i), 1'b1, 1'b0, 1'b0);
        total++;
        if (dut_vec() !== mdl_vec()) begin
          bad++; $display("FAIL bp_w%0d_b%0d: got %h want %h", k, i, dut_vec(), mdl_vec());
        end
      end
    end
    total++;
    if (bus.parallel_out !== 4'b1001 || bus.out_valid !== 1'b1 || bus.overrun !== 1'b1) begin
      bad++; $display("FAIL bp_hold: got %b/%b/%b want 1001/1/1",
                      bus.parallel_out, bus.out_valid, bus.overrun);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (bus.out_valid !== 1'b0 || bus.overrun !== 1'b1) begin
      bad++; $display("FAIL bp_drain: got valid=%b ovr=%b want 0/1", bus.out_valid, bus.overrun);
    end
  endtask

  task automatic test_realign();
    bit s_seq[6]  = '{1, 1, 1, 0, 0, 1};
    bit fs_seq[6] = '{0, 0, 1, 0, 0, 0};
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      tick(s_seq[i], 1'b1, fs_seq[i], 1'b1);
      total++;
      if (dut_vec() !== mdl_vec()) begin
        bad++; $display("FAIL realign_%0d: got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
`ifdef PISO_RX_PARITY_EN
    tick(1'b0, 1'b1, 1'b0, 1'b1);
`endif
    total++;
    if (bus.parallel_out !== 4'b1001 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL realign_word: got %b/%b want 1001/1", bus.parallel_out, bus.out_valid);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    do_reset(1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus.bit_count !== '0 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL midword_reset: got cnt=%0d valid=%b want 0/0", bus.bit_count, bus.out_valid);
    end
  endtask

`ifdef PISO_RX_PARITY_EN
  task automatic test_parity();
    bit pbit[2] = '{1, 0};
    bit perr_exp[2] = '{0, 1};
    logic [WIDTH-1:0] d = 4'b1011;
    do_reset(1);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < WIDTH; i++) tick(d[WIDTH-1-i], 1'b1, 1'b0, 1'b1);
      total++;
      if (bus.out_valid !== 1'b0 || bus.bit_count !== '0) begin
        bad++; $display("FAIL par_early%0d: got valid=%b cnt=%0d want 0/0", k, bus.out_valid, bus.bit_count);
      end
      tick(pbit[k], 1'b1, 1'b0, 1'b1);
      total++;
      if (bus.out_valid !== 1'b1 || bus.parallel_out !== 4'b1011 || bus.parity_err !== perr_exp[k]) begin
        bad++; $display("FAIL par_word%0d: got %b/%b/%b want 1011/1/%b",
                        k, bus.parallel_out, bus.out_valid, bus.parity_err, perr_exp[k]);
      end
      tick(1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask
`endif

  task automatic test_random();
    do_reset(1);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset(1);
      else tick(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 2) != 0);
      total++;
      if (dut_vec() !== mdl_vec()) begin
        bad++; $display("FAIL random_%0d: got %h want %h", n, dut_vec(), mdl_vec());
      end
    end
  endtask

  initial begin
    bus.serial_in = 1'b0; bus.bit_en = 1'b0; bus.frame_sync = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_gapped();
    test_backpressure();
    test_realign();
`ifdef PISO_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
